// File: rtl/bus_word_rx.sv
// Serial word receiver: synchronizes an external bit clock and data line, deframes
// start/8-or-16 data/stop frames and presents each word through a valid/ready holding register.
module bus_word_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic        bclk,
    input  logic        sdata,
    input  logic        cmode,
    input  logic        rd_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_bclk_sync, r_sdat_sync;
    logic                   r_bclk_hist;
    logic [4:0]             r_cnt;
    logic [15:0]            r_shift;
    logic                   r_mode;

    logic       w_bit_evt, w_sd;
    logic       w_start, w_shift, w_done, w_ferr, w_xfer;
    logic [4:0] w_cnt_inc, w_nbits;
    logic [15:0] w_word;

    // sdata flops reset high so the idle line never looks like a start bit
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_bclk_sync <= '0;
            r_sdat_sync <= '1;
            r_bclk_hist <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], bclk};
            r_sdat_sync <= {r_sdat_sync[SYNC_STAGES-2:0], sdata};
            r_bclk_hist <= r_bclk_sync[SYNC_STAGES-1];
        end
    end

    assign w_bit_evt = r_bclk_sync[SYNC_STAGES-1] & ~r_bclk_hist;
    assign w_sd      = r_sdat_sync[SYNC_STAGES-1];
    assign w_cnt_inc = r_cnt + 5'd1;
    assign w_nbits   = r_mode ? 5'd16 : 5'd8;

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_ferr      = 1'b0;
        case (r_state)
            IDLE: if (w_bit_evt && !w_sd) begin
                w_start     = 1'b1;
                w_state_nxt = SHIFT;
            end
            SHIFT: if (w_bit_evt) begin
                w_shift = 1'b1;
                if (w_cnt_inc == w_nbits) w_state_nxt = STOP;
            end
            STOP: if (w_bit_evt) begin
                w_done      = w_sd;
                w_ferr      = ~w_sd;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    // Word size is captured at the start bit so later cmode changes cannot corrupt the frame
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_start) begin
            r_mode  <= cmode;
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (w_shift) begin
            r_shift <= {r_shift[14:0], w_sd};
            r_cnt   <= w_cnt_inc;
        end
    end

    assign w_xfer = rd_valid & rd_ready;
    assign w_word = r_mode ? r_shift : {8'h00, r_shift[7:0]};

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= w_ferr;
            overrun   <= w_done & rd_valid & ~rd_ready;
            if (w_done && (!rd_valid || rd_ready)) begin
                rd_data  <= w_word;
                rd_valid <= 1'b1;
            end else if (w_xfer) begin
                rd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_word_rx.sv
// Scoreboard bench for bus_word_rx: stimulus pushes expected words, a negedge monitor
// pops them on every handshake and tracks pulse/valid counts for directed checks.
module tb_bus_word_rx;
    localparam int HALF = 8;

    logic        sysclk = 1'b0, rst_n = 1'b0, bclk = 1'b0, sdata = 1'b1, cmode = 1'b0, rd_ready = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid, frame_err, overrun, busy;

    int tests = 0, fails = 0;
    int n_ferr = 0, n_ovr = 0, n_vld = 0;
    logic [15:0] exp_q[$];
    logic        p_vld = 1'b0, p_rdy = 1'b0;
    logic [15:0] p_data = '0;

    always #5 sysclk = ~sysclk;

    bus_word_rx #(.SYNC_STAGES(2)) dut (
        .sysclk(sysclk), .rst_n(rst_n), .bclk(bclk), .sdata(sdata), .cmode(cmode),
        .rd_ready(rd_ready), .rd_data(rd_data), .rd_valid(rd_valid),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on negedge, inputs change just after posedge
    always @(negedge sysclk) begin
        if (!rst_n) begin
            p_vld = 1'b0;
            p_rdy = 1'b0;
        end else begin
            if (frame_err && overrun) chk("ferr_ovr_exclusive", 1, 0);
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
            if (rd_valid)  n_vld++;
            if (p_vld && !p_rdy) begin
                chk("hold_valid", {31'b0, rd_valid}, 1);
                chk("hold_data", {16'b0, rd_data}, {16'b0, p_data});
            end
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_word: got %0h expected none", rd_data);
                end else begin
                    chk("word", {16'b0, rd_data}, {16'b0, exp_q.pop_front()});
                end
            end
            p_vld  = rd_valid;
            p_rdy  = rd_ready;
            p_data = rd_data;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    // rdy_pulse raises rd_ready for exactly the stop-bit detection cycle (2-flop sync + history)
    task automatic send_bit(input logic b, input bit rdy_pulse);
        sdata = b;
        idle(HALF);
        bclk = 1'b1;
        if (rdy_pulse) begin
            idle(2);
            rd_ready = 1'b1;
            idle(1);
            rd_ready = 1'b0;
            idle(HALF - 3);
        end else begin
            idle(HALF);
        end
        bclk = 1'b0;
    endtask

    task automatic send_frame(input logic m, input logic [15:0] d, input logic stop,
                              input bit toggle, input bit rdy_pulse);
        int n;
        n = m ? 16 : 8;
        cmode = m;
        send_bit(1'b0, 1'b0);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(d[i], 1'b0);
            if (toggle && i == n - 4) cmode = ~cmode;
        end
        send_bit(stop, rdy_pulse);
        sdata = 1'b1;
        idle(20);
    endtask

    initial begin
        int v0, f0, o0;
        logic [15:0] part;
        #1;
        idle(3);
        chk("reset_outputs", {11'b0, rd_data, rd_valid, frame_err, overrun, busy}, 0);
        rst_n = 1'b1;
        idle(5);

        // 8-bit frame, consumer always ready
        rd_ready = 1'b1;
        v0 = n_vld;
        exp_q.push_back(16'h00A5);
        send_frame(1'b0, 16'h00A5, 1'b1, 1'b0, 1'b0);
        chk("a5_valid_cycles", n_vld - v0, 1);
        chk("a5_busy_after", {31'b0, busy}, 0);

        // 16-bit frame with cmode flipped mid-frame
        exp_q.push_back(16'h1234);
        send_frame(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
        chk("mode_latched_valid", {31'b0, rd_valid}, 0);

        // bad stop bit, then a good frame
        f0 = n_ferr;
        v0 = n_vld;
        send_frame(1'b0, 16'h003C, 1'b0, 1'b0, 1'b0);
        chk("ferr_pulses", n_ferr - f0, 1);
        chk("ferr_no_valid", n_vld - v0, 0);
        exp_q.push_back(16'h005A);
        send_frame(1'b0, 16'h005A, 1'b1, 1'b0, 1'b0);
        chk("after_ferr_ferr_count", n_ferr - f0, 1);

        // overrun: two words with no consumer
        rd_ready = 1'b0;
        o0 = n_ovr;
        exp_q.push_back(16'h0011);
        send_frame(1'b0, 16'h0011, 1'b1, 1'b0, 1'b0);
        send_frame(1'b0, 16'h0022, 1'b1, 1'b0, 1'b0);
        chk("ovr_held_data", {16'b0, rd_data}, 32'h0011);
        chk("ovr_held_valid", {31'b0, rd_valid}, 1);
        chk("ovr_pulses", n_ovr - o0, 1);
        // transfer on the completion cycle: new word loads, no overrun
        exp_q.push_back(16'h0022);
        send_frame(1'b0, 16'h0022, 1'b1, 1'b0, 1'b1);
        chk("same_cycle_data", {16'b0, rd_data}, 32'h0022);
        chk("same_cycle_valid", {31'b0, rd_valid}, 1);
        chk("same_cycle_no_ovr", n_ovr - o0, 1);
        rd_ready = 1'b1;
        idle(5);
        chk("ovr_queue_drained", exp_q.size(), 0);

        // reset mid-frame after 5 data bits of a 16-bit frame
        cmode = 1'b1;
        part = 16'hF0F0;
        send_bit(1'b0, 1'b0);
        for (int i = 15; i >= 11; i--) send_bit(part[i], 1'b0);
        idle(3);
        chk("midframe_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        chk("midframe_reset_outputs", {11'b0, rd_data, rd_valid, frame_err, overrun, busy}, 0);
        idle(4);
        rst_n = 1'b1;
        v0 = n_vld;
        for (int i = 0; i < 11; i++) send_bit(1'b1, 1'b0);
        idle(20);
        chk("remaining_bits_busy", {31'b0, busy}, 0);
        chk("remaining_bits_no_word", n_vld - v0, 0);
        exp_q.push_back(16'hBEEF);
        send_frame(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);

        // bclk high through reset release with idle data
        rst_n = 1'b0;
        bclk  = 1'b1;
        sdata = 1'b1;
        idle(4);
        rst_n = 1'b1;
        idle(10);
        chk("bclk_high_release_busy", {31'b0, busy}, 0);
        bclk = 1'b0;
        idle(10);
        chk("bclk_high_release_busy2", {31'b0, busy}, 0);
        exp_q.push_back(16'h00C3);
        send_frame(1'b0, 16'h00C3, 1'b1, 1'b0, 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/bus_word_rx.md
BUS_WORD_RX -- requirements
Module: bus_word_rx

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the number of synchronizer flops on bclk and sdata (legal 2..4).
REQ-002 The block SHALL have port sysclk  input  1  system clock; all logic is clocked on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port bclk  input  1  external bus bit clock, asynchronous to sysclk, idle low.
REQ-005 The block SHALL have port sdata  input  1  serial data, valid at bclk rising edge, idle high.
REQ-006 The block SHALL have port cmode  input  1  word-size select: 0 = 8-bit, 1 = 16-bit.
REQ-007 The block SHALL have port rd_ready  input  1  consumer ready.
REQ-008 The block SHALL have port rd_data  output  16  received word.
REQ-009 The block SHALL have port rd_valid  output  1  rd_data holds an unconsumed word.
REQ-010 The block SHALL have port frame_err  output  1  one-cycle pulse, bad stop bit.
REQ-011 The block SHALL have port overrun  output  1  one-cycle pulse, completed word dropped.
REQ-012 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 bclk and sdata SHALL each pass through SYNC_STAGES flops; a bit event is a synchronized-bclk 0->1 transition detected against a one-flop history register.
REQ-014 On each bit event the block SHALL sample the synchronized sdata; no other sysclk cycle SHALL sample data.
REQ-015 Frame format SHALL be: start bit (0), N data bits MSB first (N = 8 or 16), stop bit (1).
REQ-016 The FSM SHALL have states IDLE, SHIFT, STOP.
REQ-017 IDLE: a bit event with sdata=0 SHALL latch cmode, clear the bit counter, and go to SHIFT; a bit event with sdata=1 SHALL stay in IDLE.
REQ-018 cmode changes after the start bit SHALL NOT affect the frame in progress.
REQ-019 SHIFT: each bit event SHALL shift sdata into a 16-bit shift register LSB side and increment a 5-bit counter; after bit N it SHALL go to STOP.
REQ-020 STOP: bit event with sdata=1 SHALL complete the word and go to IDLE; sdata=0 SHALL pulse frame_err for one cycle, discard the word, and go to IDLE.
REQ-021 For 8-bit frames rd_data[15:8] SHALL be 0 and rd_data[7:0] the received byte.
REQ-022 A completed word SHALL be loaded into rd_data with rd_valid=1 on the sysclk cycle after the stop-bit event detection cycle.
REQ-023 Handshake: a transfer occurs on any cycle with rd_valid=1 and rd_ready=1; rd_valid SHALL then deassert next cycle unless a new word loads that same cycle.
REQ-024 rd_data and rd_valid SHALL be stable while rd_valid=1 and rd_ready=0.
REQ-025 A word completing while rd_valid=1 and no transfer occurs that cycle SHALL be dropped, the held word retained, and overrun pulsed one cycle.
REQ-026 A word completing on the same cycle as a transfer SHALL be loaded, rd_valid SHALL stay 1, and overrun SHALL stay 0.
REQ-027 frame_err and overrun SHALL never assert in the same cycle (a frame error produces no word).
REQ-028 busy SHALL be 1 in SHIFT and STOP, 0 in IDLE.

Reset
REQ-029 While rst_n=0: FSM=IDLE, counter=0, shift register=0, rd_data=0, rd_valid=0, frame_err=0, overrun=0, busy=0.
REQ-030 bclk synchronizer and history flops SHALL reset to 0; sdata synchronizer flops SHALL reset to 1.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame and any held word; after release the block SHALL wait for a fresh start bit.
REQ-032 Reset deassertion SHALL be synchronized to sysclk by the integration level; the block itself needs no deassertion logic.

Verification
REQ-033 cmode=0, frame 0,0xA5,1, rd_ready=1 -> rd_data=0x00A5, rd_valid high for 1 cycle, busy low afterwards.
REQ-034 cmode=1, frame 0,0x1234,1, cmode toggled mid-frame -> rd_data=0x1234 (16-bit frame kept).
REQ-035 cmode=0, frame 0,0x3C,0 (bad stop) -> frame_err one-cycle pulse, rd_valid stays 0, next good frame 0x5A is received normally.
REQ-036 rd_ready=0, frames 0x11 then 0x22 -> rd_data stays 0x0011, overrun pulses once at 0x22 completion; with rd_ready=1 on the completion cycle instead -> rd_data=0x0022, no overrun.
REQ-037 rst_n pulsed low after 5 bits of a 16-bit frame -> all outputs 0, busy 0; remaining bits are ignored (idle-high sdata is no start); next full frame 0xBEEF -> rd_data=0xBEEF.
REQ-038 bclk held high through reset release with sdata=1 -> no start, busy stays 0.
